// File: rtl/frame_buf_arbiter.sv
// Arbitrates a single SDRAM burst port between the camera write path and the
// display read path. Tracks per-frame write/read addresses and ping-pongs two
// frame banks so the display always reads the most recent complete frame.
module frame_buf_arbiter #(
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 921600,
    parameter int AW          = 20,
    parameter int UW          = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [UW-1:0] wr_usedw,
    input  logic          wr_frame_start,
    input  logic          rd_need,
    input  logic          rd_frame_start,
    output logic          sd_req,
    output logic          sd_wr,
    output logic [AW:0]   sd_addr,
    input  logic          sd_ack,
    input  logic          sd_done,
    output logic          wr_bank,
    output logic          rd_bank,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT
    } state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    localparam logic [AW-1:0] BURST_A = AW'(BURST_LEN);
    localparam logic [AW-1:0] FRAME_A = AW'(FRAME_WORDS);
    localparam logic [UW-1:0] BURST_U = UW'(BURST_LEN);

    state_t        state, state_n;
    grant_t        last_grant, last_grant_n;
    logic [AW-1:0] wr_addr, wr_addr_n;
    logic [AW-1:0] rd_addr, rd_addr_n;
    logic          last_full, last_full_n;
    logic          wr_fs_pend, wr_fs_pend_n;
    logic          rd_fs_pend, rd_fs_pend_n;
    logic          wr_bank_n, rd_bank_n;
    logic          sd_req_n, sd_wr_n, busy_n;
    logic [AW:0]   sd_addr_n;

    logic          wr_pend, rd_pend;
    logic          grant_wr, grant_rd;

    // Pending requests and round-robin choice when both sides want the port.
    always_comb begin
        wr_pend  = (wr_usedw >= BURST_U) && (wr_addr != FRAME_A);
        rd_pend  = rd_need;
        grant_wr = wr_pend && (!rd_pend || (last_grant == GRANT_RD));
        grant_rd = rd_pend && !grant_wr;
    end

    // Next-state, address bookkeeping and registered-output values.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value
        // unassigned; that is what keeps this block free of latches.
        state_n      = state;
        last_grant_n = last_grant;
        wr_addr_n    = wr_addr;
        rd_addr_n    = rd_addr;
        last_full_n  = last_full;
        wr_bank_n    = wr_bank;
        rd_bank_n    = rd_bank;
        sd_wr_n      = sd_wr;
        sd_addr_n    = sd_addr;
        // Frame-start pulses are captured in every state.
        wr_fs_pend_n = wr_fs_pend | wr_frame_start;
        rd_fs_pend_n = rd_fs_pend | rd_frame_start;

        unique case (state)
            IDLE: begin
                if (wr_fs_pend) begin
                    // Only a completed frame flips banks; a partial one is
                    // simply restarted in the same bank.
                    if (wr_addr == FRAME_A) begin
                        last_full_n = wr_bank;
                        wr_bank_n   = ~wr_bank;
                    end
                    wr_addr_n    = '0;
                    wr_fs_pend_n = wr_frame_start;
                end else if (rd_fs_pend) begin
                    rd_bank_n    = last_full;
                    rd_addr_n    = '0;
                    rd_fs_pend_n = rd_frame_start;
                end else if (grant_wr) begin
                    state_n      = WR_REQ;
                    last_grant_n = GRANT_WR;
                    sd_wr_n      = 1'b1;
                    sd_addr_n    = {wr_bank, wr_addr};
                end else if (grant_rd) begin
                    state_n      = RD_REQ;
                    last_grant_n = GRANT_RD;
                    sd_wr_n      = 1'b0;
                    sd_addr_n    = {rd_bank, rd_addr};
                end
            end
            WR_REQ: if (sd_ack) state_n = WR_WAIT;
            RD_REQ: if (sd_ack) state_n = RD_WAIT;
            WR_WAIT: begin
                if (sd_done) begin
                    wr_addr_n = (wr_addr >= FRAME_A - BURST_A) ? FRAME_A : wr_addr + BURST_A;
                    state_n   = IDLE;
                end
            end
            RD_WAIT: begin
                if (sd_done) begin
                    rd_addr_n = (rd_addr >= FRAME_A - BURST_A) ? '0 : rd_addr + BURST_A;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        sd_req_n = (state_n == WR_REQ) || (state_n == RD_REQ);
        busy_n   = (state_n != IDLE);
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_RD;
            wr_addr    <= '0;
            rd_addr    <= '0;
            last_full  <= 1'b1;
            wr_fs_pend <= 1'b0;
            rd_fs_pend <= 1'b0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b1;
            sd_req     <= 1'b0;
            sd_wr      <= 1'b0;
            sd_addr    <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values from before this edge, independent of statement order.
            state      <= state_n;
            last_grant <= last_grant_n;
            wr_addr    <= wr_addr_n;
            rd_addr    <= rd_addr_n;
            last_full  <= last_full_n;
            wr_fs_pend <= wr_fs_pend_n;
            rd_fs_pend <= rd_fs_pend_n;
            wr_bank    <= wr_bank_n;
            rd_bank    <= rd_bank_n;
            sd_req     <= sd_req_n;
            sd_wr      <= sd_wr_n;
            sd_addr    <= sd_addr_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Bench for frame_buf_arbiter: directed scenarios followed by randomized
// traffic, every burst command checked against a transaction-level model.
module tb_frame_buf_arbiter;

    localparam int BL = 16;
    localparam int FW = 128;
    localparam int AW = 8;
    localparam int UW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [UW-1:0] wr_usedw;
    logic          wr_frame_start;
    logic          rd_need;
    logic          rd_frame_start;
    logic          sd_req;
    logic          sd_wr;
    logic [AW:0]   sd_addr;
    logic          sd_ack;
    logic          sd_done;
    logic          wr_bank;
    logic          rd_bank;
    logic          busy;

    frame_buf_arbiter #(
        .BURST_LEN  (BL),
        .FRAME_WORDS(FW),
        .AW         (AW),
        .UW         (UW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_usedw      (wr_usedw),
        .wr_frame_start(wr_frame_start),
        .rd_need       (rd_need),
        .rd_frame_start(rd_frame_start),
        .sd_req        (sd_req),
        .sd_wr         (sd_wr),
        .sd_addr       (sd_addr),
        .sd_ack        (sd_ack),
        .sd_done       (sd_done),
        .wr_bank       (wr_bank),
        .rd_bank       (rd_bank),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: frame bookkeeping at the level of whole bursts.
    int m_wr_addr, m_rd_addr;
    bit m_wr_bank, m_rd_bank, m_last_full, m_last_wr, m_wr_fs, m_rd_fs;

    task automatic model_reset();
        m_wr_addr = 0; m_rd_addr = 0;
        m_wr_bank = 1'b0; m_rd_bank = 1'b1; m_last_full = 1'b1;
        m_last_wr = 1'b0; m_wr_fs = 1'b0; m_rd_fs = 1'b0;
    endtask

    // Frame starts take effect before the next arbitration, write side first.
    task automatic model_apply_fs();
        if (m_wr_fs) begin
            if (m_wr_addr == FW) begin
                m_last_full = m_wr_bank;
                m_wr_bank   = ~m_wr_bank;
            end
            m_wr_addr = 0;
            m_wr_fs   = 1'b0;
        end
        if (m_rd_fs) begin
            m_rd_bank = m_last_full;
            m_rd_addr = 0;
            m_rd_fs   = 1'b0;
        end
    endtask

    // 0 = no grant, 1 = write, 2 = read.
    function automatic int model_pick();
        bit wp, rp;
        wp = (int'(wr_usedw) >= BL) && (m_wr_addr != FW);
        rp = rd_need;
        if (wp && rp) return m_last_wr ? 2 : 1;
        if (wp) return 1;
        if (rp) return 2;
        return 0;
    endfunction

    task automatic set_inputs_random();
        case ($urandom_range(0, 3))
            0:       wr_usedw = UW'(15);
            1:       wr_usedw = UW'(16);
            default: wr_usedw = UW'($urandom_range(0, 63));
        endcase
        rd_need = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_fs(input bit w, input bit r);
        wr_frame_start = w;
        rd_frame_start = r;
        m_wr_fs = m_wr_fs | w;
        m_rd_fs = m_rd_fs | r;
        @(negedge clk);
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    // One arbitration decision. mode: 0 hold inputs, 1 randomize, 2 clear.
    task automatic step(input int mode, input bit force_rd_fs);
        int          side;
        bit          exp_wr;
        logic [AW:0] exp_addr;
        model_apply_fs();
        side = model_pick();
        if (side == 0) begin
            repeat (4) begin
                @(negedge clk);
                check("idle_noreq", sd_req, 1'b0);
            end
            check("idle_busy", busy, 1'b0);
            check("idle_wr_bank", wr_bank, m_wr_bank);
            check("idle_rd_bank", rd_bank, m_rd_bank);
            if ($urandom_range(0, 1) == 1) begin
                sd_ack = 1'b1; sd_done = 1'b1;
                @(negedge clk);
                sd_ack = 1'b0; sd_done = 1'b0;
                @(negedge clk);
                check("stray_noreq", sd_req, 1'b0);
            end
            pulse_fs(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            repeat (3) @(negedge clk);
            set_inputs_random();
            return;
        end
        for (int i = 0; i < 8 && sd_req !== 1'b1; i++) @(negedge clk);
        check("req_seen", sd_req, 1'b1);
        if (sd_req !== 1'b1) return;
        exp_wr   = (side == 1);
        exp_addr = exp_wr ? {m_wr_bank, AW'(m_wr_addr)} : {m_rd_bank, AW'(m_rd_addr)};
        check("sd_wr", sd_wr, exp_wr);
        check("sd_addr", sd_addr, exp_addr);
        check("busy_req", busy, 1'b1);
        m_last_wr = exp_wr;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("req_hold", {sd_req, sd_wr, sd_addr}, {1'b1, exp_wr, exp_addr});
        end
        sd_ack = 1'b1;
        @(negedge clk);
        sd_ack = 1'b0;
        check("req_drop", sd_req, 1'b0);
        check("busy_wait", busy, 1'b1);
        if (mode == 1) set_inputs_random();
        if (mode == 2) begin wr_usedw = '0; rd_need = 1'b0; end
        pulse_fs(mode == 1 && $urandom_range(0, 5) == 0,
                 force_rd_fs || (mode == 1 && $urandom_range(0, 5) == 0));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sd_done = 1'b1;
        @(negedge clk);
        sd_done = 1'b0;
        if (exp_wr) m_wr_addr = (m_wr_addr + BL >= FW) ? FW : m_wr_addr + BL;
        else        m_rd_addr = (m_rd_addr + BL) % FW;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_usedw = '0; rd_need = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        sd_ack = 1'b0; sd_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_sd_req", sd_req, 1'b0);
        check("rst_sd_wr", sd_wr, 1'b0);
        check("rst_sd_addr", sd_addr, '0);
        check("rst_wr_bank", wr_bank, 1'b0);
        check("rst_rd_bank", rd_bank, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // First write: one cycle from pending to sd_req, then next burst at 16.
        wr_usedw = UW'(16);
        @(negedge clk);
        check("lat1", sd_req, 1'b1);
        step(0, 1'b0);
        step(0, 1'b0);

        // Both sides held: grants alternate, starting opposite the last grant.
        wr_usedw = UW'(20); rd_need = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 1'b0);

        // Fill the rest of the frame, then writes must stay blocked.
        wr_usedw = UW'(16); rd_need = 1'b0;
        for (int i = 0; i < 20 && m_wr_addr != FW; i++) step(0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("sat_block", sd_req, 1'b0);
        end
        wr_usedw = '0;
        pulse_fs(1'b1, 1'b0);
        model_apply_fs();
        repeat (3) @(negedge clk);
        check("full_wr_bank", wr_bank, 1'b1);
        pulse_fs(1'b0, 1'b1);
        model_apply_fs();
        repeat (3) @(negedge clk);
        check("full_rd_bank", rd_bank, 1'b0);
        rd_need = 1'b1;
        step(2, 1'b0);

        // Partial frame: restart in the same bank, last_full untouched.
        wr_usedw = UW'(16);
        step(0, 1'b0); step(0, 1'b0); step(2, 1'b0);
        pulse_fs(1'b1, 1'b0);
        model_apply_fs();
        repeat (3) @(negedge clk);
        check("part_wr_bank", wr_bank, 1'b1);
        wr_usedw = UW'(16);
        step(2, 1'b0);
        pulse_fs(1'b0, 1'b1);
        model_apply_fs();
        repeat (3) @(negedge clk);
        check("part_rd_bank", rd_bank, 1'b0);

        // Display frame start during a read burst takes effect afterwards.
        rd_need = 1'b1;
        step(2, 1'b0);
        step(2, 1'b1);
        model_apply_fs();
        repeat (4) @(negedge clk);
        check("rdfs_rd_bank", rd_bank, m_rd_bank);
        rd_need = 1'b1;
        step(2, 1'b0);

        // Reset in the middle of a write burst.
        wr_usedw = UW'(16);
        for (int i = 0; i < 8 && sd_req !== 1'b1; i++) @(negedge clk);
        check("rstmid_req", sd_req, 1'b1);
        sd_ack = 1'b1;
        @(negedge clk);
        sd_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_sd_req", sd_req, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_wr_bank", wr_bank, 1'b0);
        check("rstmid_rd_bank", rd_bank, 1'b1);
        @(negedge clk);
        wr_usedw = UW'(15);
        rst_n = 1'b1;
        model_reset();
        repeat (10) begin
            @(negedge clk);
            check("rstmid_quiet", sd_req, 1'b0);
        end

        // Randomized traffic with frame starts and stray strobes.
        for (int i = 0; i < 300; i++) step(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
